// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM states, byte-enable constants,
// default wait limit, the W-stage control bundle and byte-lane helpers.
// No ports; imported by mem_stage and mem_wb_reg.
package mem_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] BE_WORD      = 4'hF;
  localparam int         MAX_WAIT_DEF = 15;

  // Control fields that travel with an instruction from M into W.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic [3:0] waddr;
  } wctl_t;

  // One-hot byte enable for a byte access at the given lane.
  function automatic logic [3:0] be_byte(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Extract one byte lane from a 32-bit word.
  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// M/W pipeline register; 1-cycle latency; bubble_i loads an empty instruction.
// Ports: clk/reset, bubble_i, ctl_i/alu_i (instruction in M), rdata_vld_i/rdata_i
// (load data capture), ctl_o/alu_o/rdata_o (instruction in W).
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble_i,
  input  wctl_t       ctl_i,
  input  logic [31:0] alu_i,
  input  logic        rdata_vld_i,
  input  logic [31:0] rdata_i,
  output wctl_t       ctl_o,
  output logic [31:0] alu_o,
  output logic [31:0] rdata_o
);

  wctl_t       ctl_q;
  logic [31:0] alu_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q   <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
    end else if (bubble_i) begin
      // Data fields are don't-care in a bubble; hold them.
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_i;
      alu_q <= alu_i;
      if (rdata_vld_i) begin
        rdata_q <= rdata_i;
      end
    end
  end

  assign ctl_o   = ctl_q;
  assign alu_o   = alu_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory accesses, waits for dmem_ack, aborts after MAX_WAIT.
// Latency: 1 cycle M->W with zero-wait ack; each cycle without ack adds one stall cycle.
// Backpressure: StallM freezes F/D/E and a bubble enters W until ack or timeout.
// Ports: execute-stage inputs (*M), dmem_* bus, StallM, BusErrM, writeback outputs (*W).
// Optional build macro MEM_STAGE_BYTE_EN adds ByteM for byte loads/stores.
module mem_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        PCSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WriteAddrM,
`ifdef MEM_STAGE_BYTE_EN
  input  logic        ByteM,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        BusErrM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WriteAddrW
);

  localparam int             CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WAIT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        need;
  logic        ack_eff;
  logic        timeout;
  logic [31:0] load_data;
  wctl_t       ctl_m;
  wctl_t       ctl_w;

  assign need = MemtoRegM | MemWriteM;

  // Request is held for the whole WAIT state, including the timeout cycle, so a
  // late ack in that cycle is still seen and wins over the abort.
  assign dmem_req = reset & (((state_q == S_IDLE) & need) | (state_q == S_WAIT));
  assign ack_eff  = dmem_req & dmem_ack;

  // cnt_q counts cycles already stalled for this access, so the timeout cycle
  // comes after exactly MAX_WAIT stall cycles.
  assign timeout  = (state_q == S_WAIT) & (cnt_q == MAX_CNT) & ~ack_eff;

  assign StallM   = reset & (need | (state_q == S_WAIT)) & ~ack_eff & ~timeout;
  assign BusErrM  = reset & timeout;
  assign dmem_we  = MemWriteM;

  // Addresses are always word-aligned; byte selection goes through dmem_be.
  assign dmem_addr = {ALUResultM[31:2], 2'b00};

`ifdef MEM_STAGE_BYTE_EN
  assign dmem_be    = ByteM ? be_byte(ALUResultM[1:0]) : BE_WORD;
  assign dmem_wdata = ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
  assign load_data  = ByteM ? {24'h0, lane_sel(dmem_rdata, ALUResultM[1:0])} : dmem_rdata;
`else
  assign dmem_be    = BE_WORD;
  assign dmem_wdata = WriteDataM;
  assign load_data  = dmem_rdata;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (need && !ack_eff) begin
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT: begin
        if (ack_eff || timeout) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An aborted access retires without writing the register file.
  always_comb begin
    ctl_m            = '0;
    ctl_m.reg_write  = RegWriteM & ~timeout;
    ctl_m.mem_to_reg = MemtoRegM;
    ctl_m.pc_src     = PCSrcM;
    ctl_m.waddr      = WriteAddrM;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .bubble_i    (StallM),
    .ctl_i       (ctl_m),
    .alu_i       (ALUResultM),
    .rdata_vld_i (ack_eff | timeout),
    .rdata_i     (timeout ? 32'h0 : load_data),
    .ctl_o       (ctl_w),
    .alu_o       (ALUOutW),
    .rdata_o     (ReadDataW)
  );

  assign RegWriteW  = ctl_w.reg_write;
  assign MemtoRegW  = ctl_w.mem_to_reg;
  assign PCSrcW     = ctl_w.pc_src;
  assign WriteAddrW = ctl_w.waddr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (MAX_WAIT=4): vector table of single-cycle
// transactions, then hand-written wait, timeout, reset and byte sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemtoRegM, MemWriteM, PCSrcM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WriteAddrM;
`ifdef MEM_STAGE_BYTE_EN
  logic        ByteM;
`endif
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        StallM, BusErrM;
  logic        RegWriteW, MemtoRegW, PCSrcW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [3:0]  WriteAddrW;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .PCSrcM     (PCSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .WriteAddrM (WriteAddrM),
`ifdef MEM_STAGE_BYTE_EN
    .ByteM      (ByteM),
`endif
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .StallM     (StallM),
    .BusErrM    (BusErrM),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .PCSrcW     (PCSrcW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WriteAddrW (WriteAddrW)
  );

  typedef struct {
    logic        rw, m2r, mw, pc;
    logic [31:0] alu, wd;
    logic [3:0]  wa;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we, e_stall;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_wrw, e_wm2r, e_wpc;
    logic [3:0]  e_wwa;
    logic [31:0] e_walu, e_wrd;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic mw, input logic pc,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
    RegWriteM  = rw;
    MemtoRegM  = m2r;
    MemWriteM  = mw;
    PCSrcM     = pc;
    ALUResultM = alu;
    WriteDataM = wd;
    WriteAddrM = wa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load that never gets an ack: MAX_WAIT stall cycles, then a single
  // BusErrM in the release cycle and a retire with no register write.
  task automatic run_timeout(input logic [31:0] addr);
    int nstall = 0;
    int nerr   = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, addr, 32'h0, 4'd7);
    dmem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (StallM)  nstall++;
      if (BusErrM) nerr++;
      chk("to_req_held", dmem_req, 1'b1);
      if (k == 4) begin
        chk("to_stall_release", StallM, 1'b0);
        chk("to_buserr", BusErrM, 1'b1);
      end
      tick();
      if (k < 4) chk("to_bubble_rw", RegWriteW, 1'b0);
    end
    chk("to_retire_rw", RegWriteW, 1'b0);
    chk("to_retire_rd", ReadDataW, 32'h0);
    chk("to_retire_alu", ALUOutW, addr);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    if (BusErrM) nerr++;
    chk("to_req_drop", dmem_req, 1'b0);
    chk("to_stall_count", nstall, 4);
    chk("to_buserr_count", nerr, 1);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 4'd3, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 4'hF,
                1'b1, 1'b0, 1'b0, 4'd3, 32'h7, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'd5, 1'b1, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF,
                1'b1, 1'b1, 1'b0, 4'd5, 32'h100, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h204, 32'hCAFEF00D, 4'd0, 1'b1, 32'h12345678,
                1'b1, 1'b1, 1'b0, 32'h204, 32'hCAFEF00D, 4'hF,
                1'b0, 1'b0, 1'b0, 4'd0, 32'h204, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 4'd15, 1'b1, 32'hAAAA5555,
                1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF,
                1'b1, 1'b0, 1'b1, 4'd15, 32'hFFFFFFFF, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 4'd0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF,
                1'b0, 1'b0, 1'b0, 4'd0, 32'h10, 32'h12345678};

    // Reset with a memory instruction present: no request may escape.
    reset      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
`ifdef MEM_STAGE_BYTE_EN
    ByteM      = 1'b0;
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'd1);
    #12;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", StallM, 1'b0);
    chk("rst_buserr", BusErrM, 1'b0);
    chk("rst_w_ctl", {RegWriteW, MemtoRegW, PCSrcW, WriteAddrW}, 7'h0);
    chk("rst_w_alu", ALUOutW, 32'h0);
    chk("rst_w_rd", ReadDataW, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single-cycle transactions from the table.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].rw, vecs[i].m2r, vecs[i].mw, vecs[i].pc, vecs[i].alu, vecs[i].wd, vecs[i].wa);
      dmem_ack   = vecs[i].ack;
      dmem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
      chk($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
      chk($sformatf("v%0d_stall", i), StallM, vecs[i].e_stall);
      chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_be", i), dmem_be, vecs[i].e_be);
      chk($sformatf("v%0d_buserr", i), BusErrM, 1'b0);
      tick();
      chk($sformatf("v%0d_wrw", i), RegWriteW, vecs[i].e_wrw);
      chk($sformatf("v%0d_wm2r", i), MemtoRegW, vecs[i].e_wm2r);
      chk($sformatf("v%0d_wpc", i), PCSrcW, vecs[i].e_wpc);
      chk($sformatf("v%0d_wwa", i), WriteAddrW, vecs[i].e_wwa);
      chk($sformatf("v%0d_walu", i), ALUOutW, vecs[i].e_walu);
      chk($sformatf("v%0d_wrd", i), ReadDataW, vecs[i].e_wrd);
    end
    dmem_ack = 1'b0;

    // Store acknowledged three cycles late.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h11112222, 4'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st3_stall", StallM, 1'b1);
      chk("st3_req", dmem_req, 1'b1);
      chk("st3_we", dmem_we, 1'b1);
      chk("st3_addr", dmem_addr, 32'h300);
      chk("st3_wdata", dmem_wdata, 32'h11112222);
      tick();
      chk("st3_bubble_rw", RegWriteW, 1'b0);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0;
    @(negedge clk);
    chk("st3_ack_stall", StallM, 1'b0);
    chk("st3_ack_we", dmem_we, 1'b1);
    tick();
    chk("st3_retire_alu", ALUOutW, 32'h300);
    dmem_ack = 1'b0;

    // Load with two wait cycles: bubbles must clear W control bits.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 4'd6);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("ld2_stall", StallM, 1'b1);
      tick();
      chk("ld2_bubble_rw", RegWriteW, 1'b0);
      chk("ld2_bubble_m2r", MemtoRegW, 1'b0);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BADCAFE;
    tick();
    chk("ld2_rw", RegWriteW, 1'b1);
    chk("ld2_m2r", MemtoRegW, 1'b1);
    chk("ld2_wa", WriteAddrW, 4'd6);
    chk("ld2_rd", ReadDataW, 32'h0BADCAFE);
    dmem_ack = 1'b0;

    run_timeout(32'h500);

    // Ack arriving in the timeout cycle completes the access normally.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 4'd8);
    for (int k = 0; k < 4; k++) tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h600DF00D;
    @(negedge clk);
    chk("tie_stall", StallM, 1'b0);
    chk("tie_buserr", BusErrM, 1'b0);
    tick();
    chk("tie_rw", RegWriteW, 1'b1);
    chk("tie_rd", ReadDataW, 32'h600DF00D);
    dmem_ack = 1'b0;

    // Asynchronous reset in the middle of a wait.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 4'd9);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_req", dmem_req, 1'b0);
    chk("mrst_stall", StallM, 1'b0);
    chk("mrst_buserr", BusErrM, 1'b0);
    chk("mrst_w_ctl", {RegWriteW, MemtoRegW, PCSrcW, WriteAddrW}, 7'h0);
    chk("mrst_w_alu", ALUOutW, 32'h0);
    chk("mrst_w_rd", ReadDataW, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_idle_req", dmem_req, 1'b0);
    tick();
    chk("mrst_no_retire", RegWriteW, 1'b0);
    // A fresh wait must count from zero again.
    run_timeout(32'h800);

`ifdef MEM_STAGE_BYTE_EN
    ByteM = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h103, 32'h5A, 4'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("byte_st_be", dmem_be, 4'b1000);
    chk("byte_st_wdata", dmem_wdata, 32'h5A5A5A5A);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 4'd2);
    dmem_rdata = 32'h11223344;
    @(negedge clk);
    chk("byte_ld_be", dmem_be, 4'b0010);
    tick();
    chk("byte_ld_rd", ReadDataW, 32'h33);
    ByteM    = 1'b0;
    dmem_ack = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of cycles an access may wait for dmem_ack before it is aborted.
- REQ-002 SHALL have: clk  in  1  single clock, all state on rising edge.
- REQ-003 SHALL have: reset  in  1  asynchronous, active-low reset.
- REQ-004 SHALL have these inputs from the execute stage:
  - RegWriteM, MemtoRegM, MemWriteM, PCSrcM  in  1 each  control bits for the instruction in M.
  - ALUResultM  in  32  address or ALU result.
  - WriteDataM  in  32  store data.
  - WriteAddrM  in  4  destination register.
- REQ-005 SHALL have the data-memory bus:
  - dmem_req  out  1;  dmem_we  out  1.
  - dmem_addr  out  32;  dmem_wdata  out  32.
  - dmem_be  out  4  byte enables.
  - dmem_ack  in  1;  dmem_rdata  in  32.
- REQ-006 SHALL have: StallM  out  1  freeze request to the F/D/E stages.
- REQ-007 SHALL have: BusErrM  out  1  one-cycle pulse on access abort.
- REQ-008 SHALL have the writeback outputs:
  - RegWriteW, MemtoRegW, PCSrcW  out  1 each.
  - ReadDataW, ALUOutW  out  32 each.
  - WriteAddrW  out  4.

Function
- REQ-009 SHALL treat an access as needed when MemtoRegM or MemWriteM is 1; a non-memory instruction SHALL pass to W in one cycle.
- REQ-010 SHALL implement FSM states IDLE and WAIT, with these transitions:
  - IDLE->WAIT when an access is needed and dmem_ack=0.
  - WAIT->IDLE on dmem_ack=1 or on timeout.
  - Otherwise the state holds.
- REQ-011 SHALL drive dmem_req=1 combinationally in IDLE when an access is needed, and throughout WAIT; dmem_we SHALL equal MemWriteM.
- REQ-012 SHALL drive dmem_addr from ALUResultM and dmem_wdata from WriteDataM; both SHALL be held stable while StallM=1, because upstream is frozen.
- REQ-013 SHALL assert StallM=(access needed or WAIT) and dmem_ack=0 and no timeout this cycle; StallM SHALL be combinational.
- REQ-014 SHALL give zero-wait access (ack in the request cycle) a latency of 1 cycle to W, with no stall.
- REQ-015 SHALL load a bubble (RegWriteW=0, PCSrcW=0, MemtoRegW=0) into the W register on every cycle where StallM=1; the data fields SHALL be don't-care.
- REQ-016 SHALL register dmem_rdata into ReadDataW on the ack cycle, and ALUResultM into ALUOutW whenever W loads a real instruction.
- REQ-017 SHALL count wait cycles with a counter that clears on IDLE entry and is sized to hold MAX_WAIT.
- REQ-018 SHALL treat the count reaching MAX_WAIT as a timeout. On timeout it SHALL:
  - drop dmem_req.
  - pulse BusErrM.
  - release StallM.
  - retire the instruction with RegWriteW=0 and ReadDataW=0.
- REQ-019 SHALL let ack win when ack and timeout coincide: the access completes normally and there is no BusErrM.
- REQ-020 SHALL ignore dmem_ack while dmem_req=0.

Reset
- REQ-021 SHALL, on reset=0, immediately force:
  - FSM to IDLE and the counter to 0.
  - All W outputs to 0, StallM=0, BusErrM=0.
- REQ-022 SHALL keep dmem_req=0 while reset=0.
- REQ-023 SHALL, on reset asserted mid-access, abandon the access with no retire and no BusErrM.

Configuration
- REQ-024 SHALL support the macro MEM_STAGE_BYTE_EN. When it is defined:
  - Input ByteM (1 bit) SHALL exist.
  - Byte store: dmem_be is one-hot on ALUResultM[1:0], and dmem_wdata replicates WriteDataM[7:0] in all four lanes.
  - Byte load: ReadDataW is the selected lane, zero-extended.
- REQ-025 SHALL behave as follows when MEM_STAGE_BYTE_EN is undefined:
  - ByteM SHALL be absent.
  - dmem_be=4'hF and dmem_addr[1:0]=2'b00.
  - ReadDataW SHALL be the full word.

Structure
- REQ-026 SHALL place the FSM state enum, byte-enable constants (BE_WORD=4'hF) and the MAX_WAIT default in shared package mem_pkg.
- REQ-027 SHALL implement the M/W pipeline register, with its bubble-load input, as sub-module mem_wb_reg; the FSM and counter SHALL stay in mem_stage.

Verification
- REQ-028 SHALL cover zero-wait load: MemtoRegM=1, ALUResultM=0x100, ack in the same cycle with rdata=0xDEADBEEF. Required response: StallM stays 0; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
- REQ-029 SHALL cover a 3-wait store: MemWriteM=1, ack 3 cycles late. Required response:
  - StallM=1 for 3 cycles, with addr/wdata constant.
  - 3 bubbles with RegWriteW=0.
  - dmem_we=1 throughout.
- REQ-030 SHALL cover timeout with MAX_WAIT=4 and ack never asserted. Required response:
  - StallM high for 4 cycles.
  - BusErrM pulses once.
  - dmem_req falls.
  - RegWriteW=0.
- REQ-031 SHALL cover mid-WAIT reset: reset=0 asynchronously. Required response: dmem_req, StallM and all W outputs go to 0 before the next edge, and the FSM is IDLE.
- REQ-032 SHALL cover, with MEM_STAGE_BYTE_EN, a byte store to 0x103 with WriteDataM=0x5A. Required response: dmem_be=4'b1000 and dmem_wdata=0x5A5A5A5A; a byte load from 0x101 with rdata=0x11223344 gives ReadDataW=0x33.
- REQ-033 SHALL cover a non-memory ALU op with ALUResultM=7 and RegWriteM=1. Required response: no dmem_req; next cycle ALUOutW=7, RegWriteW=1.
